// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory.
// Signal names are seen from the arbiter: i_* flow in, o_* flow out.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_ack;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_err;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [BE_W-1:0]   i_ls_be;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic              o_ls_ack;
    logic [DATA_W-1:0] o_ls_rdata;
    logic              o_ls_err;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [BE_W-1:0]   o_mem_be;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_stall;

    // Arbiter side
    modport master (
        input  i_if_req, i_if_addr,
        output o_if_ack, o_if_rdata, o_if_err,
        input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
        output o_ls_ack, o_ls_rdata, o_ls_err,
        output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata,
        output o_stall
    );

    // Requester / memory side
    modport slave (
        output i_if_req, i_if_addr,
        input  o_if_ack, o_if_rdata, o_if_err,
        output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
        input  o_ls_ack, o_ls_rdata, o_ls_err,
        input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata,
        input  o_stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the LSU,
// with fixed or round-robin tie-break and a per-access timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int RR      = 0
) (
    input logic          i_clk,
    input logic          i_rst,
    mem_arbiter_if.master bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_LS_BUSY
    } state_t;

    state_t            r_state;
    logic              r_last_ls;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [BE_W-1:0]   r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              r_if_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_ls_ack;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ls_err;

    logic w_if_elig;
    logic w_ls_elig;
    logic w_gnt_ls;
    logic w_gnt_if;
    logic w_tmo;

    // A requester in its ack cycle still holds req; it must not be re-granted.
    assign w_if_elig = bus.i_if_req & ~r_if_ack;
    assign w_ls_elig = bus.i_ls_req & ~r_ls_ack;
    assign w_gnt_ls  = w_ls_elig &
                       (~w_if_elig | (RR == 0) | ~r_last_ls);
    assign w_gnt_if  = w_if_elig & ~w_gnt_ls;
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == CNT_TMO);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_last_ls   <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_ls_rdata  <= '0;
            r_ls_err    <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_ls) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.i_ls_we;
                        r_mem_be    <= bus.i_ls_be;
                        r_mem_addr  <= bus.i_ls_addr;
                        r_mem_wdata <= bus.i_ls_wdata;
                        r_cnt       <= '0;
                        r_last_ls   <= 1'b1;
                        r_state     <= S_LS_BUSY;
                    end else if (w_gnt_if) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= bus.i_if_addr;
                        r_mem_wdata <= '0;
                        r_cnt       <= '0;
                        r_last_ls   <= 1'b0;
                        r_state     <= S_IF_BUSY;
                    end
                end
                S_IF_BUSY, S_LS_BUSY: begin
                    // A real ack outranks a timeout landing on the same cycle.
                    if (bus.i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                        if (r_state == S_IF_BUSY) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.i_mem_rdata;
                            r_if_err   <= 1'b0;
                        end else begin
                            r_ls_ack   <= 1'b1;
                            r_ls_rdata <= bus.i_mem_rdata;
                            r_ls_err   <= 1'b0;
                        end
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                        if (r_state == S_IF_BUSY) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= '0;
                            r_if_err   <= 1'b1;
                        end else begin
                            r_ls_ack   <= 1'b1;
                            r_ls_rdata <= '0;
                            r_ls_err   <= 1'b1;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_mem_req   = r_mem_req;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_be    = r_mem_be;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_if_ack    = r_if_ack;
    assign bus.o_if_rdata  = r_if_rdata;
    assign bus.o_if_err    = r_if_err;
    assign bus.o_ls_ack    = r_ls_ack;
    assign bus.o_ls_rdata  = r_ls_rdata;
    assign bus.o_ls_err    = r_ls_err;
    assign bus.o_stall     = (bus.i_if_req & ~r_if_ack) |
                             (bus.i_ls_req & ~r_ls_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand sequences
// for round-robin ties, timeout, ack-vs-timeout and async reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t_ifr = 0;
    logic [31:0] t_ifa = 0;
    logic        t_lsr = 0;
    logic        t_lwe = 0;
    logic [3:0]  t_lbe = 0;
    logic [31:0] t_lsa = 0;
    logic [31:0] t_lsw = 0;
    logic        t_mack = 0;
    logic [31:0] t_mrd = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.i_if_req    = t_ifr;
    assign bus0.i_if_addr   = t_ifa;
    assign bus0.i_ls_req    = t_lsr;
    assign bus0.i_ls_we     = t_lwe;
    assign bus0.i_ls_be     = t_lbe;
    assign bus0.i_ls_addr   = t_lsa;
    assign bus0.i_ls_wdata  = t_lsw;
    assign bus0.i_mem_ack   = t_mack;
    assign bus0.i_mem_rdata = t_mrd;
    assign bus1.i_if_req    = t_ifr;
    assign bus1.i_if_addr   = t_ifa;
    assign bus1.i_ls_req    = t_lsr;
    assign bus1.i_ls_we     = t_lwe;
    assign bus1.i_ls_be     = t_lbe;
    assign bus1.i_ls_addr   = t_lsa;
    assign bus1.i_ls_wdata  = t_lsw;
    assign bus1.i_mem_ack   = t_mack;
    assign bus1.i_mem_rdata = t_mrd;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .RR(0)) u_fix (
        .i_clk(clk), .i_rst(rst), .bus(bus0.master));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .RR(1)) u_rr (
        .i_clk(clk), .i_rst(rst), .bus(bus1.master));

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        lsr;
        logic        lwe;
        logic [3:0]  lbe;
        logic [31:0] lsa;
        logic [31:0] lsw;
        logic        mack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic        e_ifack;
        logic [31:0] e_ifrd;
        logic        e_lsack;
        logic [31:0] e_lsrd;
        logic        e_stall;
    } vec_t;

    vec_t vecs [12];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fetch only, held req after ack, then a store/fetch tie (RR=0).
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{1, 32'h10, 0, 0, 0, 0, 0, 1, 32'h00500093,
                     1, 0, 32'h10, 0, 0, 0, 0, 1};
        vecs[3]  = '{1, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h10, 1, 32'h00500093, 0, 0, 0};
        vecs[4]  = '{0, 32'h10, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h10, 0, 32'h00500093, 0, 0, 0};
        vecs[5]  = '{1, 32'h20, 1, 1, 4'hF, 32'h7000, 32'hDEADBEEF,
                     0, 0,
                     0, 0, 32'h10, 0, 32'h00500093, 0, 0, 1};
        vecs[6]  = '{1, 32'h20, 1, 1, 4'hF, 32'h7000, 32'hDEADBEEF,
                     0, 0,
                     1, 1, 32'h7000, 0, 32'h00500093, 0, 0, 1};
        vecs[7]  = '{1, 32'h20, 1, 1, 4'hF, 32'h7000, 32'hDEADBEEF,
                     1, 32'hCAFEF00D,
                     1, 1, 32'h7000, 0, 32'h00500093, 0, 0, 1};
        vecs[8]  = '{1, 32'h20, 1, 1, 4'hF, 32'h7000, 32'hDEADBEEF,
                     0, 0,
                     0, 1, 32'h7000, 0, 32'h00500093,
                     1, 32'hCAFEF00D, 1};
        vecs[9]  = '{1, 32'h20, 0, 0, 0, 0, 0, 1, 32'h11111111,
                     1, 0, 32'h20, 0, 32'h00500093,
                     0, 32'hCAFEF00D, 1};
        vecs[10] = '{1, 32'h20, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h20, 1, 32'h11111111,
                     0, 32'hCAFEF00D, 0};
        vecs[11] = '{0, 32'h20, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h20, 0, 32'h11111111,
                     0, 32'hCAFEF00D, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mreq", bus0.o_mem_req, 0);
        chk("rst_maddr", bus0.o_mem_addr, 0);
        chk("rst_ifack", bus0.o_if_ack, 0);
        chk("rst_lsack", bus0.o_ls_ack, 0);
        chk("rst_iferr", bus0.o_if_err, 0);
        chk("rst_lserr", bus0.o_ls_err, 0);
        chk("rst_stall", bus0.o_stall, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 12; k++) begin
            t_ifr  = vecs[k].ifr;
            t_ifa  = vecs[k].ifa;
            t_lsr  = vecs[k].lsr;
            t_lwe  = vecs[k].lwe;
            t_lbe  = vecs[k].lbe;
            t_lsa  = vecs[k].lsa;
            t_lsw  = vecs[k].lsw;
            t_mack = vecs[k].mack;
            t_mrd  = vecs[k].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_mreq", k), bus0.o_mem_req, vecs[k].e_mreq);
            chk($sformatf("v%0d_mwe", k), bus0.o_mem_we, vecs[k].e_mwe);
            chk($sformatf("v%0d_maddr", k), bus0.o_mem_addr,
                vecs[k].e_maddr);
            chk($sformatf("v%0d_ifack", k), bus0.o_if_ack, vecs[k].e_ifack);
            chk($sformatf("v%0d_ifrd", k), bus0.o_if_rdata, vecs[k].e_ifrd);
            chk($sformatf("v%0d_lsack", k), bus0.o_ls_ack, vecs[k].e_lsack);
            chk($sformatf("v%0d_lsrd", k), bus0.o_ls_rdata, vecs[k].e_lsrd);
            chk($sformatf("v%0d_stall", k), bus0.o_stall, vecs[k].e_stall);
            tick();
        end

        // Four back-to-back ties: RR alternates from LSU, fixed always LSU.
        t_lwe = 1; t_lbe = 4'hF; t_lsa = 32'h7000; t_lsw = 32'hDEADBEEF;
        t_ifa = 32'h20; t_mrd = 32'h12345678;
        for (int t = 0; t < 4; t++) begin
            tick();
            t_ifr = 1; t_lsr = 1;
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d_req", t), bus1.o_mem_req, 1);
            chk($sformatf("rr%0d_addr", t), bus1.o_mem_addr,
                (t % 2 == 0) ? 32'h7000 : 32'h20);
            chk($sformatf("rr%0d_we", t), bus1.o_mem_we,
                (t % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("fix%0d_addr", t), bus0.o_mem_addr, 32'h7000);
            chk($sformatf("fix%0d_wdata", t), bus0.o_mem_wdata,
                32'hDEADBEEF);
            chk($sformatf("fix%0d_be", t), bus0.o_mem_be, 4'hF);
            tick();
            t_mack = 1;
            tick();
            t_mack = 0; t_ifr = 0; t_lsr = 0;
        end

        // Load timeout after 4 busy cycles, then a late ack is ignored.
        tick();
        t_lsr = 1; t_lwe = 0; t_lsa = 32'h40;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("tmo_busy%0d", c), bus0.o_mem_req, 1);
        end
        tick();
        @(negedge clk);
        chk("tmo_mreq", bus0.o_mem_req, 0);
        chk("tmo_ack", bus0.o_ls_ack, 1);
        chk("tmo_err", bus0.o_ls_err, 1);
        chk("tmo_rdata", bus0.o_ls_rdata, 0);
        t_lsr = 0;
        tick();
        t_mack = 1;
        tick();
        t_mack = 0;
        @(negedge clk);
        chk("late_mreq", bus0.o_mem_req, 0);
        chk("late_ack", bus0.o_ls_ack, 0);
        chk("late_err", bus0.o_ls_err, 1);
        chk("late_rdata", bus0.o_ls_rdata, 0);

        // Ack on the would-be timeout cycle wins and clears err.
        tick();
        t_lsr = 1; t_lsa = 32'h44;
        repeat (3) tick();
        tick();
        t_mack = 1; t_mrd = 32'hA5A5A5A5;
        tick();
        t_mack = 0;
        @(negedge clk);
        chk("win_ack", bus0.o_ls_ack, 1);
        chk("win_err", bus0.o_ls_err, 0);
        chk("win_rdata", bus0.o_ls_rdata, 32'hA5A5A5A5);
        t_lsr = 0;

        // Async reset while LS_BUSY, then re-grant of the held request.
        tick();
        t_lsr = 1; t_lsa = 32'h50;
        tick();
        @(negedge clk);
        chk("pre_rst_mreq", bus0.o_mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mreq", bus0.o_mem_req, 0);
        chk("arst_lsack", bus0.o_ls_ack, 0);
        chk("arst_ifack", bus0.o_if_ack, 0);
        chk("arst_stall", bus0.o_stall, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("regrant_mreq", bus0.o_mem_req, 1);
        chk("regrant_addr", bus0.o_mem_addr, 32'h50);
        tick();
        t_mack = 1; t_mrd = 32'h0BADF00D;
        tick();
        t_mack = 0;
        @(negedge clk);
        chk("regrant_ack", bus0.o_ls_ack, 1);
        chk("regrant_rdata", bus0.o_ls_rdata, 32'h0BADF00D);
        t_lsr = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
